// File: rtl/fetch_unit.sv
// fetch_unit: BRAM instruction fetch with a 2-stage in-flight tracker and a decode queue.
// Optional macro FETCH_BYPASS_EN presents a response in its arrival cycle when the queue is empty.
module fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              redirect_in,
  input  logic [31:0]       redirect_pc_in,
  input  logic              ready_in,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic [31:0]       imem_data_in,
  output logic              valid_out,
  output logic [31:0]       inst_out,
  output logic [31:0]       pc_out,
  output logic              halt_out
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] LP_DEPTH = (PW+2)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_epoch;
  logic          r_halt;
  logic          r_s1_v;
  logic          r_s2_v;
  logic [31:0]   r_s1_pc;
  logic [31:0]   r_s2_pc;
  logic          r_s1_ep;
  logic          r_s2_ep;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;

  logic          w_empty;
  logic          w_resp;
  logic          w_halt_det;
  logic          w_accept;
  logic          w_issue;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_inflight;
  logic [PW+1:0] w_used;
  logic [31:0]   w_head_inst;
  logic [31:0]   w_head_pc;
  logic          w_unused;

  assign w_unused = ^redirect_pc_in[1:0];

  assign w_empty = (r_count == '0);
  assign w_inflight = {1'b0, r_s1_v} + {1'b0, r_s2_v};
  assign w_used = (PW+2)'(r_count)
                + (PW+2)'(w_inflight);

  // Stale-epoch responses and anything arriving under a redirect are dropped
  assign w_resp = r_s2_v && (r_s2_ep == r_epoch)
               && !redirect_in;
  assign w_halt_det = w_resp
                   && (imem_data_in == '0)
                   && (r_s2_pc != '0);
  assign w_accept = w_resp && !w_halt_det;

  assign w_issue = (w_used < LP_DEPTH)
                && !r_halt && !w_halt_det
                && !redirect_in;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_accept && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head_inst = w_empty ? imem_data_in
                               : r_q_inst[r_rd];
  assign w_head_pc = w_empty ? r_s2_pc
                             : r_q_pc[r_rd];

  assign valid_out = (!w_empty || w_bypass)
                  && !redirect_in && !rst_in;
  assign inst_out = valid_out ? w_head_inst : '0;
  assign pc_out = valid_out ? w_head_pc : '0;
  assign halt_out = r_halt;
  assign imem_addr_out = r_fetch_pc[ADDR_W+1:2];

  assign w_pop = valid_out && ready_in && !w_empty;
  assign w_push = w_accept
               && !(w_bypass && ready_in);

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_q_inst[r_wr] <= imem_data_in;
      r_q_pc[r_wr] <= r_s2_pc;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc <= '0;
      r_epoch <= 1'b0;
      r_halt <= 1'b0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s1_pc <= '0;
      r_s2_pc <= '0;
      r_s1_ep <= 1'b0;
      r_s2_ep <= 1'b0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_s1_v <= w_issue;
      r_s1_pc <= r_fetch_pc;
      r_s1_ep <= r_epoch;
      r_s2_v <= r_s1_v && !w_halt_det;
      r_s2_pc <= r_s1_pc;
      r_s2_ep <= r_s1_ep;
      if (redirect_in) begin
        r_fetch_pc <= {redirect_pc_in[31:2], 2'b00};
        r_epoch <= ~r_epoch;
        r_halt <= 1'b0;
        r_wr <= '0;
        r_rd <= '0;
        r_count <= '0;
      end else begin
        if (w_issue)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_halt_det)
          r_halt <= 1'b1;
        if (w_push)
          r_wr <= r_wr + PW'(1);
        if (w_pop)
          r_rd <= r_rd + PW'(1);
        r_count <= r_count
                 + (PW+1)'(w_push)
                 - (PW+1)'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a
// program-order stream model with a 2-cycle BRAM model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 10;
  localparam int MW = 1 << ADDR_W;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              redirect_in;
  logic [31:0]       redirect_pc_in;
  logic              ready_in;
  logic [ADDR_W-1:0] imem_addr_out;
  logic [31:0]       imem_data_in;
  logic              valid_out;
  logic [31:0]       inst_out;
  logic [31:0]       pc_out;
  logic              halt_out;

  always #5 clk_in = ~clk_in;

  fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .ready_in(ready_in),
    .imem_addr_out(imem_addr_out),
    .imem_data_in(imem_data_in),
    .valid_out(valid_out),
    .inst_out(inst_out),
    .pc_out(pc_out),
    .halt_out(halt_out)
  );

  logic [31:0] mem [MW];
  logic [31:0] r_d1;
  logic [31:0] r_d2;

  always @(posedge clk_in) begin
    r_d1 <= mem[imem_addr_out];
    r_d2 <= r_d1;
  end
  assign imem_data_in = r_d2;

  int          n_chk;
  int          n_err;
  int          n_deliv;
  logic [31:0] exp_pc;
  logic        p_hold;
  logic [31:0] p_pc;
  logic [31:0] p_inst;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic halt_word(input logic [31:0] pc);
    return (mem[pc[ADDR_W+1:2]] == 32'd0) && (pc != 32'd0);
  endfunction

  // One clock: drive inputs mid-cycle, then score what the DUT shows
  task automatic step(input logic rst, input logic rdy,
                      input logic redir,
                      input logic [31:0] rpc);
    @(negedge clk_in);
    rst_in = rst;
    ready_in = rdy;
    redirect_in = redir;
    redirect_pc_in = rpc;
    #1;
    if (rst) begin
      chk("rst_valid", 32'(valid_out), 32'd0);
      exp_pc = 32'd0;
      p_hold = 1'b0;
    end else begin
      if (p_hold && !redir) begin
        chk("hold_v", 32'(valid_out), 32'd1);
        chk("hold_pc", pc_out, p_pc);
        chk("hold_inst", inst_out, p_inst);
      end
      if (redir)
        chk("redir_valid", 32'(valid_out), 32'd0);
      if (valid_out && rdy) begin
        if (halt_word(exp_pc)) begin
          chk("halt_leak", 32'(valid_out), 32'd0);
        end else begin
          chk("pc", pc_out, exp_pc);
          chk("inst", inst_out, mem[exp_pc[ADDR_W+1:2]]);
          exp_pc = exp_pc + 32'd4;
          n_deliv++;
        end
      end
      if (redir)
        exp_pc = {rpc[31:2], 2'b00};
      p_hold = valid_out && !rdy;
      p_pc = pc_out;
      p_inst = inst_out;
    end
  endtask

  task automatic wait_valid(input int maxc, output int k);
    k = -1;
    for (int i = 0; i < maxc; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (valid_out) begin
        k = i;
        break;
      end
    end
    if (k < 0)
      chk("wait_tmo", 32'(valid_out), 32'd1);
  endtask

  task automatic fill_nz();
    for (int i = 0; i < MW; i++)
      mem[i] = $urandom() | 32'd1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [ADDR_W-1:0] a_frz;
    logic r;
    n_chk = 0;
    n_err = 0;
    n_deliv = 0;
    exp_pc = 32'd0;
    p_hold = 1'b0;
    p_pc = 32'd0;
    p_inst = 32'd0;
    rst_in = 1'b1;
    ready_in = 1'b0;
    redirect_in = 1'b0;
    redirect_pc_in = 32'd0;

    // Latency and back-to-back delivery
    fill_nz();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_addr", 32'(imem_addr_out), 32'd0);
    chk("rst_halt", 32'(halt_out), 32'd0);
    for (int c = 0; c <= LAT + 2; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (c < LAT) begin
        chk("lat_pre", 32'(valid_out), 32'd0);
      end else begin
        chk("seq_v", 32'(valid_out), 32'd1);
        chk("seq_pc", pc_out, 32'((c - LAT) * 4));
      end
    end

    // Back-pressure fills the queue and freezes the address
    fill_nz();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      if (c >= 6)
        chk("frz_addr", 32'(imem_addr_out), 32'd4);
    end
    chk("full_v", 32'(valid_out), 32'd1);
    chk("full_pc", pc_out, 32'd0);
    n_deliv = 0;
    for (int c = 0; c < 12; c++)
      step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rel_n", 32'(n_deliv >= 5), 32'd1);

    // Redirect with requests in flight
    fill_nz();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    wait_valid(12, k);
    chk("redir_lat", 32'(k), 32'(LAT));
    chk("redir_pc", pc_out, 32'h40);

    // Zero word at 0x10 halts fetch
    fill_nz();
    mem[4] = 32'd0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    n_deliv = 0;
    a_frz = '0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (c == 15)
        a_frz = imem_addr_out;
    end
    chk("halt_n", 32'(n_deliv), 32'd4);
    chk("halt_set", 32'(halt_out), 32'd1);
    chk("halt_frz", 32'(imem_addr_out), 32'(a_frz));
    chk("halt_v", 32'(valid_out), 32'd0);

    // Reset with a full queue
    fill_nz();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 10; c++)
      step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    wait_valid(12, k);
    chk("rst_lat", 32'(k), 32'(LAT));
    chk("rst_refetch", pc_out, 32'd0);

    // Redirect in the halt-detect cycle wins
    fill_nz();
    mem[4] = 32'd0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 6; c++)
      step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h20);
    wait_valid(12, k);
    chk("hr_halt", 32'(halt_out), 32'd0);
    chk("hr_lat", 32'(k), 32'(LAT));
    chk("hr_pc", pc_out, 32'h20);

    // Random traffic, redirects and resets
    for (int i = 0; i < MW; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      r = ($urandom_range(0, 3) != 0);
      step(k == 0, r, (k >= 1) && (k <= 5), $urandom());
    end
    for (int i = 0; i < 24; i++)
      step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("end_halt", 32'(halt_out), 32'(halt_word(exp_pc)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 10, instruction BRAM word-address width.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port redirect_in, input, 1: flush and restart fetch at redirect_pc_in.
REQ-006 SHALL have port redirect_pc_in, input, 32: byte address of the new fetch target.
REQ-007 SHALL have port ready_in, input, 1: decode accepts the presented instruction.
REQ-008 SHALL have port imem_addr_out, output, ADDR_W: word address driven to the instruction BRAM.
REQ-009 SHALL have port imem_data_in, input, 32: BRAM read data, valid exactly 2 cycles after its address.
REQ-010 SHALL have port valid_out, output, 1: inst_out and pc_out hold a valid instruction.
REQ-011 SHALL have port inst_out, output, 32: fetched instruction.
REQ-012 SHALL have port pc_out, output, 32: byte address of inst_out.
REQ-013 SHALL have port halt_out, output, 1: sticky end-of-program flag.

Function
REQ-014 SHALL hold fetch_pc; imem_addr_out = fetch_pc[ADDR_W+1:2]; redirect_pc_in[1:0] ignored (forced 0).
REQ-015 SHALL issue one request per cycle when (in-flight + queue occupancy) < DEPTH, !halt_out, !redirect_in; issue advances fetch_pc by 4 (32-bit wrap).
REQ-016 SHALL track in-flight requests in a 2-deep shift register of {valid, pc, epoch}; a response is accepted in the cycle its entry reaches stage 2.
REQ-017 SHALL push accepted responses {imem_data_in, pc} into a FIFO of DEPTH entries; credit rule (REQ-015) guarantees no overflow; push on full is a design error.
REQ-018 SHALL present the FIFO head: valid_out = !empty && !redirect_in; pop when valid_out && ready_in; simultaneous push and pop legal at any occupancy.
REQ-019 SHALL hold inst_out/pc_out stable while valid_out && !ready_in.
REQ-020 SHALL on redirect_in: fetch_pc <= {redirect_pc_in[31:2],2'b00}, flush FIFO, toggle epoch, clear halt_out; first new request issues the following cycle.
REQ-021 SHALL discard any response whose epoch differs from the current epoch.
REQ-022 SHALL, for an accepted response with imem_data_in == 0 and pc != 0, not enqueue it, set halt_out, and stop issuing; in-flight responses behind it are discarded.
REQ-023 SHALL keep halt_out set until rst_in or redirect_in; redirect_in wins over a same-cycle halt detection.
REQ-024 SHALL, with cycle 0 = first cycle rst_in low and ready_in high, issue pc 0 in cycle 0 and assert valid_out with pc_out=0 in cycle 3, then one instruction per cycle.
REQ-025 SHALL, with ready_in low from cycle 0, reach steady state with exactly DEPTH instructions buffered and imem_addr_out frozen.

Reset
REQ-026 SHALL on rst_in high at an edge: fetch_pc=0, FIFO empty, in-flight valid bits 0, epoch 0, halt_out=0.
REQ-027 SHALL drive valid_out=0, inst_out=0, pc_out=0, imem_addr_out=0 during and after reset until new data arrives.
REQ-028 SHALL treat reset asserted mid-operation identically, discarding all buffered and in-flight data.

Configuration
REQ-029 SHALL support macro FETCH_BYPASS_EN: defined -> an accepted response with FIFO empty is presented directly on outputs in its arrival cycle (latency 2, first valid_out cycle 2) and consumed without push if ready_in; undefined -> all responses pass through the FIFO (latency 3).

Verification
REQ-030 SHALL test: reset, BRAM holds nonzero words at 0,4,8, ready_in=1 -> valid_out cycle 3 (cycle 2 with FETCH_BYPASS_EN), pc_out 0,4,8 on consecutive cycles.
REQ-031 SHALL test: ready_in=0 for 10 cycles, DEPTH=4 -> 4 entries buffered, imem_addr_out stops at word 4, release gives pc 0,4,8,12,16 in order without loss.
REQ-032 SHALL test: redirect_in to 0x40 with 2 requests in flight -> no pc 0x8/0xC delivered, next valid pc_out = 0x40.
REQ-033 SHALL test: zero word at 0x10 -> pc_out 0..0xC delivered, halt_out=1, 0x10 never valid, imem_addr_out frozen.
REQ-034 SHALL test: rst_in high for one cycle with FIFO full -> valid_out=0 next cycle, refetch from pc 0.
REQ-035 SHALL test: redirect_in to 0x20 in the cycle halt is detected -> halt_out=0, fetch resumes at 0x20.
